// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for a single-port
// data memory. Requester 0 is the load/store unit, requester 1 the debug/DMA
// loader. Each accepted request runs IDLE -> ACCESS -> RESP, so one word
// transaction completes every three cycles at most. Every output is a register.
module dmem_arbiter #(
    parameter int DEPTH = 64,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    // requester 0 (load/store unit)
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    output logic          err0,
    // requester 1 (debug / DMA loader)
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          err1,
    // single-port memory
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // sequencing state
    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;     // port that won the previous arbitration
    logic          sel_q, sel_d;       // port owning the transaction in flight
    logic          oor_q, oor_d;       // latched address is out of range

    // registered outputs
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    // arbitration helpers
    logic          win1;
    logic          win_we;
    logic          win_oor;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic [DW-1:0] capture;

    // Pick the winner: a lone requester wins, a tie goes to the port that did not win last.
    always_comb begin
        win1      = req1 & (~req0 | ~last_q);
        win_we    = win1 ? we1    : we0;
        win_addr  = win1 ? addr1  : addr0;
        win_wdata = win1 ? wdata1 : wdata0;
        win_oor   = (win_addr >= AW'(DEPTH));
        // A legal read is exactly the case where the read enable was raised.
        capture   = mem_re_q ? mem_rdata : '0;
    end

    // Next-state and next-output logic for the three-phase sequence.
    always_comb begin
        // NOTE: every target gets a default first (hold for state, 0 for pulses) so no path infers a latch.
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        oor_d       = oor_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_d     = S_ACCESS;
                    sel_d       = win1;
                    last_d      = win1;
                    oor_d       = win_oor;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                    mem_we_d    = win_we & ~win_oor;
                    mem_re_d    = ~win_we & ~win_oor;
                    gnt0_d      = ~win1;
                    gnt1_d      = win1;
                end
            end
            S_ACCESS: begin
                // The write commits and the read data is captured on the edge leaving ACCESS.
                state_d = S_RESP;
                if (sel_q) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = capture;
                    err1_d    = oor_q;
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = capture;
                    err0_d    = oor_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            oor_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            oor_q       <= oor_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port data memory (64 x 32-bit words, combinational read, write on posedge clk).
- Requester 0 is the core load/store unit. Requester 1 is the debug/DMA loader.
- Each requester issues one word transaction per handshake. The block serialises them with round-robin priority, drives the memory control/address/data lines from registers, and returns read data with a completion pulse.

Parameters:
- DEPTH, 64, number of memory words; legal word addresses are 0..DEPTH-1.
- AW, 32, address width of requester and memory ports.
- DW, 32, data width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req0 / req1  input  1  transaction request, held until gnt.
- we0 / we1  input  1  1 = write, 0 = read; valid with req.
- addr0 / addr1  input  AW  word address.
- wdata0 / wdata1  input  DW  write data.
- gnt0 / gnt1  output  1  one-cycle accept pulse.
- rvalid0 / rvalid1  output  1  one-cycle completion pulse; asserted for reads and writes.
- rdata0 / rdata1  output  DW  read data, valid with rvalid.
- err0 / err1  output  1  address out of range, valid with rvalid.
- mem_we  output  1  memory write enable.
- mem_re  output  1  memory read enable.
- mem_addr  output  AW  memory word address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory combinational read data.

Behaviour:
- All outputs are registered.
- Reset clears every output to 0, sets state = IDLE and last = 1, so port 0 wins the first tie.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. A transaction takes exactly 3 cycles; the maximum rate is 1 transaction per 3 cycles.
- IDLE:
  - req0/req1 are sampled only in this state.
  - If none is asserted, stay in IDLE.
  - Winner selection: if only one port requests, it wins. If both request, the winner is the port != last.
  - On the edge, latch the winner's we/addr/wdata and set sel = winner, last = winner.
  - Compute range check: oor = (addr >= DEPTH).
  - Go to ACCESS.
- ACCESS (one cycle):
  - gnt[sel] = 1.
  - mem_addr = latched addr and mem_wdata = latched wdata.
  - mem_we = we & !oor; mem_re = !we & !oor.
  - The memory write commits on the edge that ends ACCESS.
  - On that same edge, capture the read result: mem_rdata for a legal read, otherwise 0.
  - Go to RESP.
- RESP (one cycle):
  - rvalid[sel] = 1 and rdata[sel] = captured value.
  - err[sel] = oor.
  - mem_we and mem_re are 0.
  - Go to IDLE.
- The non-selected port's gnt, rvalid and err are 0 at all times. Its rdata holds its last value.
- Requester rules:
  - A requester may drop req in the cycle after gnt.
  - If req is still high when the FSM is next in IDLE, it is a new transaction.
- Out-of-range access:
  - The memory is never enabled.
  - A write is discarded; a read returns 0.
  - err is set with rvalid.
- mem_addr and mem_wdata hold their last values outside ACCESS. Only the enables qualify them.
- A request that arrives while the FSM is in ACCESS or RESP waits until IDLE. No request is lost as long as req stays held.
- Reset mid-transaction (any state):
  - On the next cycle, all outputs are 0, state = IDLE and last = 1.
  - The in-flight transaction is dropped: no rvalid is issued.
  - If reset is asserted during ACCESS, the write enable in that cycle is still observed by the memory on the same edge. The memory's own reset takes precedence.

Test Plan:
- Single read: mem[5] = 0xDEADBEEF; req0=1, we0=0, addr0=5 at cycle 0 -> cycle 1: gnt0=1, mem_re=1, mem_addr=5; cycle 2: rvalid0=1, rdata0=0xDEADBEEF, err0=0.
- Write then read back: port 1 writes 0x12345678 to addr 10 -> mem_we=1 in ACCESS only; port 0 then reads addr 10 -> rdata0=0x12345678.
- Contention: both ports hold req right after reset -> grants come in the order 0, 1, 0, 1 on cycles 1, 4, 7, 10. Each rvalid follows its gnt by 1 cycle.
- Out of range: req1 write, addr1=64, wdata1=0xFFFFFFFF -> mem_we stays 0; rvalid1=1 with err1=1 and rdata1=0; mem[0] and mem[63] unchanged. Repeat as a read -> rdata1=0, err1=1.
- Reset mid-operation: rst=1 during ACCESS of a port-1 read -> next cycle all outputs are 0 and no rvalid1 is issued. A following simultaneous req0/req1 grants port 0 first.
- Streaming: req0 held high alone for 9 cycles -> gnt0 on cycles 1, 4, 7; rvalid0 on cycles 2, 5, 8; req1 is never granted while it stays low.
